// File: rtl/ddr_dly_line_ctrl_pkg.sv
// Shared definitions for the IOD dynamic delay-line sequencer.
//   cmd_op_e  : command encodings carried on CMD_OP
//   state_e   : sequencer states
//   tap_w()   : tap-index width for a given number of taps
package ddr_dly_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_GOTO = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_GAP   = 3'd3,
    ST_LOADP = 3'd4,
    ST_FIN   = 3'd5
  } state_e;

  // ceil(log2(n)), never less than 1
  function automatic int tap_w(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/ddr_dly_line_ctrl_if.sv
// Command/status interface between a tap requester (training or VT
// compensation) and the delay-line sequencer.
//   master : requester side, drives CMD_VALID/CMD_OP/CMD_ARG
//   slave  : sequencer side, drives CMD_READY/DONE/ERR/OOR_STICKY/CUR_TAP/BUSY
interface ddr_dly_line_ctrl_if #(
  parameter int TAP_W = 7
);
  logic             CMD_VALID;
  logic             CMD_READY;
  logic [1:0]       CMD_OP;
  logic [TAP_W-1:0] CMD_ARG;
  logic             DONE;
  logic             ERR;
  logic             OOR_STICKY;
  logic [TAP_W-1:0] CUR_TAP;
  logic             BUSY;

  modport master (
    output CMD_VALID, CMD_OP, CMD_ARG,
    input  CMD_READY, DONE, ERR, OOR_STICKY, CUR_TAP, BUSY
  );

  modport slave (
    input  CMD_VALID, CMD_OP, CMD_ARG,
    output CMD_READY, DONE, ERR, OOR_STICKY, CUR_TAP, BUSY
  );
endinterface

// File: rtl/ddr_dly_line_ctrl.sv
// Sequencer for one PolarFire IOD dynamic delay line. Turns one tap command
// at a time into spaced single-cycle MOVE pulses or a LOAD pulse, tracks the
// current tap and reports saturation.
// Ports:
//   FAB_CLK                 fabric clock, rising edge
//   ARST_N                  asynchronous active-low reset
//   cmd                     command/status interface (slave side)
//   DELAY_LINE_MOVE         to IOD, one pulse per tap step
//   DELAY_LINE_DIRECTION    to IOD, 1 = increment delay
//   DELAY_LINE_LOAD         to IOD, reload TX/RX_DELAY_VAL
//   DELAY_LINE_OUT_OF_RANGE from IOD, synchronous to FAB_CLK
//
// state | meaning
// IDLE  | ready for a command; steps/direction computed at accept
// SETUP | direction settles one cycle ahead of the first MOVE
// PULSE | MOVE high for one cycle
// GAP   | MOVE_GAP idle cycles; out-of-range sampled in the last one
// LOADP | LOAD high for LOAD_CYCLES cycles
// FIN   | DONE pulse, ERR if clipped or aborted
module ddr_dly_line_ctrl
  import ddr_dly_pkg::*;
#(
  parameter int NUM_TAPS    = 128,
  parameter int LOAD_VAL    = 1,
  parameter int MOVE_GAP    = 4,
  parameter int LOAD_CYCLES = 2
) (
  input  logic                FAB_CLK,
  input  logic                ARST_N,
  ddr_dly_line_ctrl_if.slave  cmd,
  output logic                DELAY_LINE_MOVE,
  output logic                DELAY_LINE_DIRECTION,
  output logic                DELAY_LINE_LOAD,
  input  logic                DELAY_LINE_OUT_OF_RANGE
);

  localparam int TAP_W   = tap_w(NUM_TAPS);
  localparam int TMR_MAX = (MOVE_GAP > LOAD_CYCLES) ? MOVE_GAP : LOAD_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TAP_W-1:0] MAX_TAP  = TAP_W'(NUM_TAPS - 1);
  localparam logic [TAP_W-1:0] LOAD_TAP = TAP_W'(LOAD_VAL);

  state_e           state, state_nxt;
  logic [TAP_W-1:0] cur_tap;
  logic [TAP_W-1:0] steps_q;
  logic             dir_q;
  logic             err_q;
  logic             oor_q;
  logic [TMR_W-1:0] tmr;

  logic             accept;
  cmd_op_e          op_in;
  logic [TAP_W-1:0] steps_calc;
  logic [TAP_W-1:0] headroom;
  logic [TAP_W-1:0] target;
  logic             dir_calc;
  logic             clip_calc;

  assign op_in    = cmd_op_e'(cmd.CMD_OP);
  assign headroom = MAX_TAP - cur_tap;

  // Step count, direction and clip flag for the command being offered
  always_comb begin
    steps_calc = '0;
    dir_calc   = 1'b0;
    clip_calc  = 1'b0;
    target     = '0;
    case (op_in)
      OP_INC: begin
        dir_calc = 1'b1;
        if (cmd.CMD_ARG > headroom) begin
          steps_calc = headroom;
          clip_calc  = 1'b1;
        end else begin
          steps_calc = cmd.CMD_ARG;
        end
      end
      OP_DEC: begin
        if (cmd.CMD_ARG > cur_tap) begin
          steps_calc = cur_tap;
          clip_calc  = 1'b1;
        end else begin
          steps_calc = cmd.CMD_ARG;
        end
      end
      OP_GOTO: begin
        if (cmd.CMD_ARG > MAX_TAP) begin
          target    = MAX_TAP;
          clip_calc = 1'b1;
        end else begin
          target = cmd.CMD_ARG;
        end
        if (target > cur_tap) begin
          dir_calc   = 1'b1;
          steps_calc = target - cur_tap;
        end else begin
          steps_calc = cur_tap - target;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    accept          = 1'b0;
    cmd.CMD_READY   = 1'b0;
    cmd.DONE        = 1'b0;
    cmd.ERR         = 1'b0;
    DELAY_LINE_MOVE = 1'b0;
    DELAY_LINE_LOAD = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd.CMD_READY = 1'b1;
        if (cmd.CMD_VALID) begin
          accept = 1'b1;
          if (op_in == OP_LOAD)      state_nxt = ST_LOADP;
          else if (steps_calc == '0) state_nxt = ST_FIN;
          else                       state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: state_nxt = ST_PULSE;
      ST_PULSE: begin
        DELAY_LINE_MOVE = 1'b1;
        state_nxt       = ST_GAP;
      end
      ST_GAP: begin
        if (tmr == '0) begin
          if (DELAY_LINE_OUT_OF_RANGE || steps_q == TAP_W'(1)) state_nxt = ST_FIN;
          else                                                 state_nxt = ST_PULSE;
        end
      end
      ST_LOADP: begin
        DELAY_LINE_LOAD = 1'b1;
        if (tmr == '0) state_nxt = ST_FIN;
      end
      ST_FIN: begin
        cmd.DONE  = 1'b1;
        cmd.ERR   = err_q;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      cur_tap <= LOAD_TAP;
      steps_q <= '0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
      oor_q   <= 1'b0;
      tmr     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            steps_q <= steps_calc;
            err_q   <= clip_calc;
            if (op_in == OP_LOAD)      tmr   <= TMR_W'(LOAD_CYCLES - 1);
            else if (steps_calc != '0) dir_q <= dir_calc;
          end
        end
        ST_PULSE: tmr <= TMR_W'(MOVE_GAP - 1);
        ST_GAP: begin
          if (tmr != '0) begin
            tmr <= tmr - 1'b1;
          end else if (DELAY_LINE_OUT_OF_RANGE) begin
            // IOD refused the step: keep the tap, drop the rest of the command
            oor_q   <= 1'b1;
            err_q   <= 1'b1;
            steps_q <= '0;
          end else begin
            cur_tap <= dir_q ? cur_tap + 1'b1 : cur_tap - 1'b1;
            steps_q <= steps_q - 1'b1;
          end
        end
        ST_LOADP: begin
          if (tmr != '0) begin
            tmr <= tmr - 1'b1;
          end else begin
            cur_tap <= LOAD_TAP;
            oor_q   <= 1'b0;
          end
        end
        ST_FIN: err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign DELAY_LINE_DIRECTION = dir_q;
  assign cmd.CUR_TAP          = cur_tap;
  assign cmd.OOR_STICKY       = oor_q;
  assign cmd.BUSY             = (state != ST_IDLE);

endmodule

// File: tb/tb_ddr_dly_line_ctrl.sv
module tb_ddr_dly_line_ctrl;

  localparam int OP_LOAD = 0;
  localparam int OP_INC  = 1;
  localparam int OP_DEC  = 2;
  localparam int OP_GOTO = 3;

  logic clk;
  logic rst_n;
  logic move;
  logic dir;
  logic load;
  logic oor;

  ddr_dly_line_ctrl_if #(.TAP_W(7)) cmd_if ();

  ddr_dly_line_ctrl #(
    .NUM_TAPS(128), .LOAD_VAL(1), .MOVE_GAP(4), .LOAD_CYCLES(2)
  ) dut (
    .FAB_CLK                 (clk),
    .ARST_N                  (rst_n),
    .cmd                     (cmd_if.slave),
    .DELAY_LINE_MOVE         (move),
    .DELAY_LINE_DIRECTION    (dir),
    .DELAY_LINE_LOAD         (load),
    .DELAY_LINE_OUT_OF_RANGE (oor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_err;

  int move_q[$];
  int load_n;
  int load_first;
  int dir_first;
  int dir_moved;
  int done_cyc;
  int err_done;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int mv(input int i);
    return (i < move_q.size()) ? move_q[i] : -1;
  endfunction

  // Issue one command at a negedge (cycle 0) and trace cycles 1..DONE.
  // oor_from > 0 drives OUT_OF_RANGE high from that cycle onward.
  task automatic run_cmd(input int op, input int arg, input int oor_from);
    bit got_done;
    @(negedge clk);
    chk("ready_before_cmd", int'(cmd_if.CMD_READY), 1);
    cmd_if.CMD_VALID = 1'b1;
    cmd_if.CMD_OP    = 2'(op);
    cmd_if.CMD_ARG   = 7'(arg);
    move_q.delete();
    load_n     = 0;
    load_first = -1;
    dir_first  = -1;
    dir_moved  = 0;
    done_cyc   = -1;
    err_done   = 0;
    got_done   = 0;
    for (int k = 1; k <= 2000 && !got_done; k++) begin
      @(negedge clk);
      if (k == 1) cmd_if.CMD_VALID = 1'b0;
      if (move) move_q.push_back(k);
      if (load) begin
        if (load_first < 0) load_first = k;
        load_n++;
      end
      if (k == 1) dir_first = int'(dir);
      else if (int'(dir) != dir_first) dir_moved = 1;
      if (cmd_if.DONE) begin
        done_cyc = k;
        err_done = int'(cmd_if.ERR);
        got_done = 1;
      end
      if (oor_from > 0) oor = (k >= oor_from);
    end
    oor = 1'b0;
    if (!got_done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    bit saw_done;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    oor   = 1'b0;
    cmd_if.CMD_VALID = 1'b0;
    cmd_if.CMD_OP    = 2'b00;
    cmd_if.CMD_ARG   = '0;

    repeat (3) @(negedge clk);
    chk("rst_ready", int'(cmd_if.CMD_READY), 1);
    chk("rst_busy",  int'(cmd_if.BUSY), 0);
    chk("rst_done",  int'(cmd_if.DONE), 0);
    chk("rst_oor",   int'(cmd_if.OOR_STICKY), 0);
    chk("rst_tap",   int'(cmd_if.CUR_TAP), 1);
    chk("rst_move",  int'(move), 0);
    chk("rst_dir",   int'(dir), 0);
    chk("rst_load",  int'(load), 0);
    rst_n = 1'b1;

    run_cmd(OP_LOAD, 0, 0);
    chk("load_done_cyc",   done_cyc, 3);
    chk("load_first",      load_first, 1);
    chk("load_len",        load_n, 2);
    chk("load_tap",        int'(cmd_if.CUR_TAP), 1);
    chk("load_err",        err_done, 0);

    run_cmd(OP_INC, 3, 0);
    chk("inc3_dir",        dir_first, 1);
    chk("inc3_dir_stable", dir_moved, 0);
    chk("inc3_nmove",      move_q.size(), 3);
    chk("inc3_move0",      mv(0), 2);
    chk("inc3_move1",      mv(1), 7);
    chk("inc3_move2",      mv(2), 12);
    chk("inc3_done_cyc",   done_cyc, 17);
    chk("inc3_tap",        int'(cmd_if.CUR_TAP), 4);
    chk("inc3_err",        err_done, 0);
    chk("inc3_busy_fin",   int'(cmd_if.BUSY), 1);

    run_cmd(OP_GOTO, 2, 0);
    chk("goto2_dir",       dir_first, 0);
    chk("goto2_nmove",     move_q.size(), 2);
    chk("goto2_done_cyc",  done_cyc, 12);
    chk("goto2_tap",       int'(cmd_if.CUR_TAP), 2);

    run_cmd(OP_GOTO, 2, 0);
    chk("goto_same_done",  done_cyc, 1);
    chk("goto_same_nmove", move_q.size(), 0);
    chk("goto_same_err",   err_done, 0);

    run_cmd(OP_GOTO, 125, 0);
    chk("goto125_done",    done_cyc, 1 + 123 * 5 + 1);
    chk("goto125_tap",     int'(cmd_if.CUR_TAP), 125);

    run_cmd(OP_INC, 10, 0);
    chk("incsat_nmove",    move_q.size(), 2);
    chk("incsat_tap",      int'(cmd_if.CUR_TAP), 127);
    chk("incsat_done_cyc", done_cyc, 12);
    chk("incsat_err",      err_done, 1);

    run_cmd(OP_DEC, 0, 0);
    chk("dec0_done_cyc",   done_cyc, 1);
    chk("dec0_err",        err_done, 0);
    chk("dec0_nmove",      move_q.size(), 0);

    run_cmd(OP_GOTO, 4, 0);
    chk("goto4_tap",       int'(cmd_if.CUR_TAP), 4);
    chk("goto4_dir",       dir_first, 0);

    run_cmd(OP_DEC, 5, 8);
    chk("oor_nmove",       move_q.size(), 2);
    chk("oor_tap",         int'(cmd_if.CUR_TAP), 3);
    chk("oor_done_cyc",    done_cyc, 12);
    chk("oor_err",         err_done, 1);
    chk("oor_sticky",      int'(cmd_if.OOR_STICKY), 1);

    run_cmd(OP_DEC, 1, 0);
    chk("oor_sticky_hold", int'(cmd_if.OOR_STICKY), 1);
    chk("oor_next_err",    err_done, 0);

    run_cmd(OP_LOAD, 0, 0);
    chk("oor_load_clr",    int'(cmd_if.OOR_STICKY), 0);
    chk("oor_load_tap",    int'(cmd_if.CUR_TAP), 1);

    // Abort an INC 6 with reset in its second gap (cycle 9, tap already 2)
    @(negedge clk);
    cmd_if.CMD_VALID = 1'b1;
    cmd_if.CMD_OP    = 2'(OP_INC);
    cmd_if.CMD_ARG   = 7'd6;
    saw_done = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) cmd_if.CMD_VALID = 1'b0;
      if (cmd_if.DONE) saw_done = 1;
    end
    chk("abort_pre_tap",   int'(cmd_if.CUR_TAP), 2);
    chk("abort_pre_busy",  int'(cmd_if.BUSY), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_move",      int'(move), 0);
    chk("abort_tap",       int'(cmd_if.CUR_TAP), 1);
    chk("abort_done",      int'(cmd_if.DONE), 0);
    chk("abort_ready",     int'(cmd_if.CMD_READY), 1);
    chk("abort_dir",       int'(dir), 0);
    chk("abort_no_done",   int'(saw_done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_cmd(OP_INC, 1, 0);
    chk("post_rst_nmove",  move_q.size(), 1);
    chk("post_rst_done",   done_cyc, 7);
    chk("post_rst_tap",    int'(cmd_if.CUR_TAP), 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ddr_dly_line_ctrl.md
Name: ddr_dly_line_ctrl

Overview:
Sequencer for the dynamic delay line of one PolarFire IOD lane in the DDR3 PHY block (DELAY_LINE_MOVE / DIRECTION / LOAD / OUT_OF_RANGE pins). It accepts one tap command at a time from training or VT-compensation logic over a valid/ready interface. Each command is converted into correctly spaced single-cycle MOVE pulses or a LOAD pulse. The block tracks the current tap and reports saturation. One instance sits beside each IOD that has DYN_DELAY_LINE_EN set.

Parameters:
NUM_TAPS, 128, number of delay taps; TAP_W = clog2(NUM_TAPS).
LOAD_VAL, 1, tap value the IOD returns to on LOAD; must match the IOD TX/RX_DELAY_VAL.
MOVE_GAP, 4, idle cycles after each MOVE pulse before the next pulse or completion (minimum 1).
LOAD_CYCLES, 2, width of the DELAY_LINE_LOAD pulse in cycles (minimum 1).

Ports:
FAB_CLK  in  1  fabric clock; all logic on rising edge.
ARST_N  in  1  asynchronous active-low reset.
CMD_VALID  in  1  command request.
CMD_READY  out  1  high only in IDLE.
CMD_OP  in  2  00 LOAD, 01 INC, 10 DEC, 11 GOTO.
CMD_ARG  in  TAP_W  step count for INC/DEC; absolute target for GOTO; ignored for LOAD.
DONE  out  1  one-cycle pulse at command completion.
ERR  out  1  one-cycle pulse with DONE when the command was clipped or aborted.
OOR_STICKY  out  1  set on any hardware out-of-range; cleared only by LOAD or reset.
CUR_TAP  out  TAP_W  current tap estimate.
BUSY  out  1  inverse of CMD_READY.
DELAY_LINE_MOVE  out  1  to IOD; one-cycle pulse per tap step.
DELAY_LINE_DIRECTION  out  1  to IOD; 1 = increment delay.
DELAY_LINE_LOAD  out  1  to IOD.
DELAY_LINE_OUT_OF_RANGE  in  1  from IOD; synchronous to FAB_CLK.

Behaviour:
- Reset values: CMD_READY=1, BUSY=0, DONE=0, ERR=0, OOR_STICKY=0, CUR_TAP=LOAD_VAL, MOVE=0, DIRECTION=0, LOAD=0, state IDLE, step counter 0.
- ARST_N asserted mid-command aborts it immediately. No DONE is issued. All outputs take their reset values asynchronously.
- A command is accepted when CMD_VALID && CMD_READY in IDLE (cycle 0). CMD_OP and CMD_ARG are registered at acceptance.
- State machine: IDLE -> SETUP | LOADP | FIN; SETUP -> PULSE; PULSE -> GAP; GAP -> PULSE | FIN; LOADP -> FIN; FIN -> IDLE.
- Step computation at accept:
  - INC: steps = min(ARG, NUM_TAPS-1-CUR_TAP).
  - DEC: steps = min(ARG, CUR_TAP).
  - GOTO: target = min(ARG, NUM_TAPS-1); direction = target > CUR_TAP; steps = |target - CUR_TAP|.
  - Clipping sets an internal err flag.
- If steps = 0 (not LOAD), the next state is FIN directly, with DONE in cycle 1.
- SETUP (1 cycle): DIRECTION is driven and then held stable until FIN. MOVE stays 0.
- PULSE (1 cycle): MOVE=1.
- GAP (MOVE_GAP cycles): MOVE=0. DELAY_LINE_OUT_OF_RANGE is sampled in the last GAP cycle.
  - If it is low: CUR_TAP moves ±1 and steps decrements. The next state is PULSE if steps > 0, else FIN.
  - If it is high: CUR_TAP is not updated, OOR_STICKY is set, err is set, remaining steps are discarded, and the next state is FIN.
- LOADP: LOAD=1 for LOAD_CYCLES cycles. CUR_TAP is set to LOAD_VAL and OOR_STICKY cleared on exit.
- FIN (1 cycle): DONE=1 and ERR=err. err is cleared. CMD_READY returns the following cycle.
- Latency for INC/DEC/GOTO with N>0 steps: DONE in cycle 1 + N*(1+MOVE_GAP) + 1.
- Latency for LOAD: DONE in cycle LOAD_CYCLES + 1.
- CUR_TAP never wraps: it stays within 0..NUM_TAPS-1 at all times.
- CMD_VALID while BUSY is ignored (no queueing). The requester must hold VALID until READY.

Decomposition:
- Shared package ddr_dly_pkg: CMD_OP encodings, state enumeration, and the TAP_W derivation function.
- No sub-modules are required. A small down-counter is inline for the gap/load timer.

Test Plan:
- Reset, then LOAD: DONE at cycle 3, LOAD high in cycles 1-2, CUR_TAP=1, ERR=0.
- INC ARG=3 from tap 1, defaults: DIRECTION=1 from cycle 1; MOVE pulses at cycles 2, 7, 12; DONE at cycle 17; CUR_TAP=4; ERR=0.
- GOTO ARG=2 from tap 4: DIRECTION=0, 2 MOVE pulses, DONE at cycle 12, CUR_TAP=2. Then GOTO ARG=2: DONE at cycle 1, no MOVE pulses.
- INC ARG=10 from tap 125 (NUM_TAPS=128): exactly 2 MOVE pulses, CUR_TAP=127, DONE with ERR=1. Then DEC ARG=0: immediate DONE, ERR=0.
- DEC ARG=5 from tap 4, with OUT_OF_RANGE forced high before the second gap sample:
  - 2 MOVE pulses; CUR_TAP=3; DONE and ERR at cycle 12; OOR_STICKY=1.
  - A subsequent LOAD clears OOR_STICKY and sets CUR_TAP=1.
- ARST_N low during the GAP of an INC ARG=6: MOVE=0 and CUR_TAP=1 immediately; no DONE. After release, READY=1 and a new command is accepted normally.
